// File: rtl/matrix_loader_pkg.sv
// Shared types and helpers for the matrix loader: FSM states, cfg_len slice width,
// and the length-to-beat conversion.
package matrix_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSel,
        StLoad,
        StFin
    } state_e;

    // Each per-channel length field is one bit wider than the address so 2**AW fits.
    function automatic int unsigned len_w(input int unsigned aw);
        return aw + 1;
    endfunction

    // Two words per beat; an odd length rounds up to a final half-used beat.
    function automatic int unsigned beats_of(input int unsigned len);
        return (len + 1) / 2;
    endfunction

endpackage

// File: rtl/matrix_loader_pair_addr_counter.sv
// Beat counter for one channel fill: yields the even/odd word address pair of the
// current beat and flags the beat that reaches the target beat count.
module pair_addr_counter #(
    parameter int unsigned AW = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_en,
    input  logic [AW-1:0] i_target,
    output logic [AW-1:0] o_addr_even,
    output logic [AW-1:0] o_addr_odd,
    output logic          o_last
);

    logic [AW-1:0] r_k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k <= '0;
        end else if (i_clear) begin
            r_k <= '0;
        end else if (i_en) begin
            r_k <= r_k + 1'b1;
        end
    end

    assign o_addr_even = {r_k[AW-2:0], 1'b0};
    assign o_addr_odd  = {r_k[AW-2:0], 1'b1};
    assign o_last      = (({1'b0, r_k} + 1'b1) == {1'b0, i_target});

endmodule

// File: rtl/matrix_loader.sv
// Streams two-word beats into NCH dual-port RAM channels in order, lane 0 on port A
// (even addresses) and lane 1 on port B (odd). Define MATRIX_LOADER_CHECKSUM_EN for the word sum.
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int unsigned NCH = 3,
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [NCH*(AW+1)-1:0]    i_cfg_len,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [DW-1:0]            i_in_data0,
    input  logic [DW-1:0]            i_in_data1,
    output logic [NCH-1:0]           o_wea,
    output logic [NCH*AW-1:0]        o_addra,
    output logic [NCH*DW-1:0]        o_dina,
    output logic [NCH-1:0]           o_web,
    output logic [NCH*AW-1:0]        o_addrb,
    output logic [NCH*DW-1:0]        o_dinb,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [DW-1:0]            o_checksum
);

    localparam int unsigned LW = len_w(AW);
    localparam int unsigned CW = $clog2(NCH + 1);

    state_e        r_state, w_state_d;
    logic [LW-1:0] r_len [NCH];
    logic [CW-1:0] r_ch, w_ch_d;
    logic [LW-1:0] w_cur_len;
    logic [AW-1:0] w_target;
    logic          w_found;
    logic [CW-1:0] w_next_ch;
    logic          w_start_acc;
    logic          w_fire;
    logic          w_last;
    logic          w_odd_tail;
    logic [AW-1:0] w_addr_even, w_addr_odd;

    logic          r_we_a, r_we_b;
    logic [CW-1:0] r_wr_ch;
    logic [AW-1:0] r_addr_a, r_addr_b;
    logic [DW-1:0] r_din_a, r_din_b;

    assign w_start_acc = (r_state == StIdle) && i_start;
    assign o_in_ready  = (r_state == StLoad);
    assign w_fire      = o_in_ready && i_in_valid;
    assign w_odd_tail  = w_last && w_cur_len[0];
    assign o_busy      = (r_state == StSel) || (r_state == StLoad);
    assign o_done      = (r_state == StFin);

    always_comb begin
        w_cur_len = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_ch == CW'(i)) w_cur_len = r_len[i];
        end
    end

    assign w_target = AW'(beats_of(32'(w_cur_len)));

    // First nonzero-length channel at or after the current index.
    always_comb begin
        w_found   = 1'b0;
        w_next_ch = r_ch;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && (CW'(i) >= r_ch) && (r_len[i] != '0)) begin
                w_found   = 1'b1;
                w_next_ch = CW'(i);
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ch_d    = r_ch;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StSel;
                    w_ch_d    = '0;
                end
            end
            StSel: begin
                if (w_found) begin
                    w_state_d = StLoad;
                    w_ch_d    = w_next_ch;
                end else begin
                    w_state_d = StFin;
                end
            end
            StLoad: begin
                if (w_fire && w_last) begin
                    w_state_d = StSel;
                    w_ch_d    = r_ch + 1'b1;
                end
            end
            StFin:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_ch    <= '0;
            for (int i = 0; i < NCH; i++) r_len[i] <= '0;
        end else begin
            r_state <= w_state_d;
            r_ch    <= w_ch_d;
            if (w_start_acc) begin
                for (int i = 0; i < NCH; i++) r_len[i] <= i_cfg_len[i*LW +: LW];
            end
        end
    end

    pair_addr_counter #(
        .AW (AW)
    ) u_pair_addr_counter (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (r_state != StLoad),
        .i_en        (w_fire),
        .i_target    (w_target),
        .o_addr_even (w_addr_even),
        .o_addr_odd  (w_addr_odd),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we_a   <= 1'b0;
            r_we_b   <= 1'b0;
            r_wr_ch  <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_din_a  <= '0;
            r_din_b  <= '0;
        end else begin
            r_we_a <= w_fire;
            r_we_b <= w_fire && !w_odd_tail;
            if (w_fire) begin
                r_wr_ch  <= r_ch;
                r_addr_a <= w_addr_even;
                r_addr_b <= w_addr_odd;
                r_din_a  <= i_in_data0;
                r_din_b  <= i_in_data1;
            end
        end
    end

    // Only the written channel sees nonzero address/data, and only in its strobe cycle.
    always_comb begin
        o_wea   = '0;
        o_web   = '0;
        o_addra = '0;
        o_addrb = '0;
        o_dina  = '0;
        o_dinb  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_wr_ch == CW'(i)) begin
                o_wea[i] = r_we_a;
                o_web[i] = r_we_b;
                if (r_we_a) begin
                    o_addra[i*AW +: AW] = r_addr_a;
                    o_dina[i*DW +: DW]  = r_din_a;
                end
                if (r_we_b) begin
                    o_addrb[i*AW +: AW] = r_addr_b;
                    o_dinb[i*DW +: DW]  = r_din_b;
                end
            end
        end
    end

`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [DW-1:0] r_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_start_acc) begin
            r_sum <= '0;
        end else if (w_fire) begin
            r_sum <= r_sum + i_in_data0 + (w_odd_tail ? '0 : i_in_data1);
        end
    end

    assign o_checksum = r_sum;
`else
    assign o_checksum = '0;
`endif

endmodule
